// File: rtl/vend_dispense_sequencer.sv
// Dispense sequencer: runs the product motor for a sale, then pays the change
// greedily (dollars first, then quarters) through a req/ack coin hopper.
// A motor timeout cancels the sale and adds the price back into the refund.
module vend_dispense_sequencer #(
   parameter int W             = 16,
   parameter int MOTOR_TIMEOUT = 1000,
   parameter int DOLLAR        = 100,
   parameter int QUARTER       = 25
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         vend,
   input  logic [3:0]   start_selection,
   input  logic [W-1:0] start_price,
   input  logic [W-1:0] start_change,
   output logic         busy,
   output logic         motor_req,
   output logic [3:0]   motor_slot,
   input  logic         motor_done,
   output logic         coin_req,
   output logic         coin_type,
   input  logic         coin_ack,
   output logic [W-1:0] remaining,
   output logic         done,
   output logic         fault,
   output logic         short
);

   typedef enum logic [2:0] {S_IDLE, S_MOTOR, S_COIN, S_GAP, S_DONE} state_t;

   // Counter only has to reach MOTOR_TIMEOUT-1: the timeout fires on that edge.
   localparam int CNT_W = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MOTOR_TIMEOUT - 1);
   localparam logic [W-1:0]     DOLLAR_C  = W'(DOLLAR);
   localparam logic [W-1:0]     QUARTER_C = W'(QUARTER);

   state_t             state_q, state_d;
   logic [3:0]         slot_q, slot_d;
   logic [W-1:0]       price_q, price_d;
   logic [W-1:0]       rem_q, rem_d;
   logic               ctype_q, ctype_d;
   logic               fault_q, fault_d;
   logic               short_q, short_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, mreq_q, creq_q, done_q;

   // Refund add clamps at all-ones instead of wrapping.
   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[W] ? {W{1'b1}} : sum[W-1:0];
   endfunction

   // Anything below a quarter cannot be paid, so it ends the transaction.
   function automatic state_t payout_state(input logic [W-1:0] rem);
      return (rem >= QUARTER_C) ? S_COIN : S_DONE;
   endfunction

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      price_d = price_q;
      rem_d   = rem_q;
      ctype_d = ctype_q;
      fault_d = fault_q;
      short_d = short_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               slot_d  = start_selection;
               price_d = start_price;
               rem_d   = start_change;
               fault_d = 1'b0;
               short_d = 1'b0;
               cnt_d   = '0;
               state_d = vend ? S_MOTOR : payout_state(start_change);
            end
         end
         S_MOTOR: begin
            // motor_done has priority over a timeout on the same edge.
            if (motor_done) begin
               state_d = payout_state(rem_q);
            end else if (cnt_q == CNT_LAST) begin
               fault_d = 1'b1;
               rem_d   = sat_add(rem_q, price_q);
               state_d = payout_state(rem_d);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_COIN: begin
            if (coin_ack) begin
               rem_d   = rem_q - (ctype_q ? DOLLAR_C : QUARTER_C);
               state_d = S_GAP;
            end
         end
         S_GAP:   state_d = payout_state(rem_q);
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Coin denomination is frozen on entry to COIN and held until the ack.
      if (state_d == S_COIN && state_q != S_COIN) ctype_d = (rem_d >= DOLLAR_C);
      // Unpayable residual flagged once, on entry to DONE.
      if (state_d == S_DONE && state_q != S_DONE) short_d = (rem_d != '0);
   end

   // State, datapath and registered output strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         slot_q  <= '0;
         price_q <= '0;
         rem_q   <= '0;
         ctype_q <= 1'b0;
         fault_q <= 1'b0;
         short_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         mreq_q  <= 1'b0;
         creq_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         price_q <= price_d;
         rem_q   <= rem_d;
         ctype_q <= ctype_d;
         fault_q <= fault_d;
         short_q <= short_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != S_IDLE);
         mreq_q  <= (state_d == S_MOTOR);
         creq_q  <= (state_d == S_COIN);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign busy       = busy_q;
   assign motor_req  = mreq_q;
   assign motor_slot = slot_q;
   assign coin_req   = creq_q;
   assign coin_type  = ctype_q;
   assign remaining  = rem_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign short      = short_q;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Scoreboard bench for vend_dispense_sequencer: each start pushes the expected
// coin sequence and final result; the hopper responder and done monitor pop them.
module tb_vend_dispense_sequencer;

   localparam int W    = 16;
   localparam int TMO  = 8;
   localparam int DOL  = 100;
   localparam int QTR  = 25;
   localparam int WMAX = (1 << W) - 1;

   logic         clk;
   logic         reset;
   logic         start;
   logic         vend;
   logic [3:0]   start_selection;
   logic [W-1:0] start_price;
   logic [W-1:0] start_change;
   logic         busy;
   logic         motor_req;
   logic [3:0]   motor_slot;
   logic         motor_done;
   logic         coin_req;
   logic         coin_type;
   logic         coin_ack;
   logic [W-1:0] remaining;
   logic         done;
   logic         fault;
   logic         short;

   typedef struct {bit typ; int rem;} coin_t;
   typedef struct {int rem; bit flt; bit sht;} fin_t;

   coin_t coin_q[$];
   fin_t  fin_q[$];

   int  n_checks = 0;
   int  n_fail   = 0;
   int  motor_cycles = 0;
   int  coin_cycles  = 0;
   bit  ack_en    = 1'b1;
   bit  stray_ack = 1'b0;

   vend_dispense_sequencer #(.W(W), .MOTOR_TIMEOUT(TMO), .DOLLAR(DOL), .QUARTER(QTR)) dut (
      .clk(clk), .reset(reset), .start(start), .vend(vend),
      .start_selection(start_selection), .start_price(start_price), .start_change(start_change),
      .busy(busy), .motor_req(motor_req), .motor_slot(motor_slot), .motor_done(motor_done),
      .coin_req(coin_req), .coin_type(coin_type), .coin_ack(coin_ack),
      .remaining(remaining), .done(done), .fault(fault), .short(short)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Greedy payout reference: dollars while >= 100, then quarters while >= 25.
   task automatic push_txn(input bit timeout, input int price, input int change);
      int rem;
      bit t;
      rem = change;
      if (timeout) rem = (rem + price > WMAX) ? WMAX : rem + price;
      while (rem >= QTR) begin
         t = (rem >= DOL);
         coin_q.push_back('{t, rem});
         rem -= t ? DOL : QTR;
      end
      fin_q.push_back('{rem, timeout, rem != 0});
   endtask

   task automatic do_start(input bit v, input int sel, input int price, input int change);
      @(negedge clk);
      start = 1'b1; vend = v;
      start_selection = 4'(sel); start_price = W'(price); start_change = W'(change);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic motor_respond(input int dly, input int sel, input string tag);
      int n = 0;
      while (!motor_req && n < 10) begin @(negedge clk); n++; end
      chk({tag, "_motor_req"}, motor_req, 1);
      chk({tag, "_slot"}, motor_slot, sel);
      repeat (dly) @(negedge clk);
      motor_done = 1'b1;
      @(negedge clk);
      motor_done = 1'b0;
      chk({tag, "_motor_drop"}, motor_req, 0);
   endtask

   task automatic motor_timeout_run(input int exp_rem, input string tag);
      int n = 0;
      while (motor_req && n < 20) begin n++; @(negedge clk); end
      chk({tag, "_motor_cycles"}, n, TMO);
      chk({tag, "_fault"}, fault, 1);
      chk({tag, "_rem_after_tmo"}, remaining, exp_rem);
   endtask

   task automatic wait_done(input int budget, input string tag);
      fin_t f;
      int n = 0;
      while (!done && n < budget) begin @(negedge clk); n++; end
      if (!done) begin
         chk({tag, "_done_seen"}, 0, 1);
         coin_q.delete();
         fin_q.delete();
         return;
      end
      f = fin_q.pop_front();
      chk({tag, "_rem"}, remaining, f.rem);
      chk({tag, "_fault"}, fault, f.flt);
      chk({tag, "_short"}, short, f.sht);
      chk({tag, "_coins_left"}, coin_q.size(), 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   // Hopper model: checks each requested coin against the scoreboard, then acks it.
   initial begin
      coin_t c;
      coin_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_en && coin_req && !coin_ack) begin
            if (coin_q.size() == 0) begin
               chk("coin_unexpected", 1, 0);
            end else begin
               c = coin_q.pop_front();
               chk("coin_type", coin_type, c.typ);
               chk("coin_rem", remaining, c.rem);
            end
            coin_ack = 1'b1;
         end else begin
            coin_ack = stray_ack && !coin_req;
         end
      end
   end

   // Activity counters for "never requested" checks.
   initial begin
      forever begin
         @(negedge clk);
         if (motor_req) motor_cycles++;
         if (coin_req)  coin_cycles++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int m0;
      int c0;
      reset = 1'b1; start = 1'b0; vend = 1'b0; start_selection = '0;
      start_price = '0; start_change = '0; motor_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_motor_req", motor_req, 0);
      chk("rst_motor_slot", motor_slot, 0);
      chk("rst_coin_req", coin_req, 0);
      chk("rst_coin_type", coin_type, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_short", short, 0);
      reset = 1'b0;

      // Sale with 50c change: two quarters.
      push_txn(0, 150, 50);
      do_start(1, 2, 150, 50);
      motor_respond(3, 2, "t1");
      wait_done(60, "t1");

      // Sale with 175c change: dollar then three quarters.
      push_txn(0, 100, 175);
      do_start(1, 7, 100, 175);
      motor_respond(0, 7, "t2");
      wait_done(60, "t2");

      // Refund only: one dollar, motor untouched.
      m0 = motor_cycles;
      push_txn(0, 0, 100);
      do_start(0, 3, 0, 100);
      wait_done(20, "t3");
      chk("t3_no_motor", motor_cycles - m0, 0);

      // Refund of zero: done on the cycle right after the start edge.
      c0 = coin_cycles;
      push_txn(0, 0, 0);
      do_start(0, 3, 0, 0);
      wait_done(0, "t3z");
      chk("t3z_no_coin", coin_cycles - c0, 0);

      // Motor timeout: price refunded as two dollars.
      push_txn(1, 200, 0);
      do_start(1, 14, 200, 0);
      motor_timeout_run(200, "t4");
      wait_done(60, "t4");

      // motor_done on the timeout edge wins: no fault, nothing owed.
      push_txn(0, 200, 0);
      do_start(1, 14, 200, 0);
      motor_respond(TMO - 1, 14, "t4c");
      wait_done(10, "t4c");

      // Timeout refund saturates at all-ones.
      push_txn(1, WMAX, 100);
      do_start(1, 9, WMAX, 100);
      motor_timeout_run(WMAX, "sat");
      wait_done(5000, "sat");

      // Stray ack and motor_done while idle change nothing.
      @(negedge clk);
      stray_ack = 1'b1; motor_done = 1'b1;
      repeat (2) @(negedge clk);
      stray_ack = 1'b0; motor_done = 1'b0;
      @(negedge clk);
      chk("stray_rem", remaining, 10);
      chk("stray_busy", busy, 0);

      // 60c refund leaves 10c short; start and motor_done while busy ignored.
      m0 = motor_cycles;
      push_txn(0, 0, 60);
      do_start(0, 5, 0, 60);
      @(negedge clk);
      start = 1'b1; vend = 1'b1; start_selection = 4'd11;
      start_price = W'(300); start_change = W'(500);
      @(negedge clk);
      start = 1'b0; motor_done = 1'b1;
      @(negedge clk);
      motor_done = 1'b0;
      wait_done(60, "t5");
      chk("t5_slot", motor_slot, 5);
      chk("t5_no_motor", motor_cycles - m0, 0);

      // Asynchronous reset while a coin is outstanding.
      ack_en = 1'b0;
      push_txn(0, 0, 300);
      do_start(0, 4, 0, 300);
      chk("t6_coin_req_pre", coin_req, 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_coin_req", coin_req, 0);
      chk("t6_busy", busy, 0);
      chk("t6_remaining", remaining, 0);
      chk("t6_fault", fault, 0);
      coin_q.delete();
      fin_q.delete();
      @(negedge clk);
      reset = 1'b0;
      ack_en = 1'b1;
      push_txn(0, 0, 125);
      do_start(0, 6, 0, 125);
      wait_done(60, "t6");
      chk("t6_slot", motor_slot, 6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
